pipe_control: RTL and testbench

Pipelined control unit for the 5-stage MIPS datapath. It decodes the instruction held in IF/ID (opcode plus funct) into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards and jumps and drives the PC and IF/ID enable, select and flush lines. It replaces the single-register decoder with true opcode/funct decoding, per-stage control registers, stall/flush handling and an illegal-opcode flag.

---
 rtl/pipe_ctrl_pkg.sv | 61 ++++++
 rtl/pipe_control_hazard_unit.sv | 37 +++
 rtl/pipe_control.sv | 156 +++++++++++++++
 tb/tb_pipe_control.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipelined MIPS control unit: opcodes, functs,
// ALU select codes and the per-stage control bundles.
package pipe_ctrl_pkg;

    localparam int PKG_REG_AW = 5;
    localparam int PKG_ALU_W  = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;

    localparam logic [PKG_ALU_W-1:0] ALU_ADD = 4'h0;
    localparam logic [PKG_ALU_W-1:0] ALU_SUB = 4'h1;
    localparam logic [PKG_ALU_W-1:0] ALU_SLL = 4'h2;
    localparam logic [PKG_ALU_W-1:0] ALU_SRL = 4'h3;
    localparam logic [PKG_ALU_W-1:0] ALU_AND = 4'h8;
    localparam logic [PKG_ALU_W-1:0] ALU_OR  = 4'h9;
    localparam logic [PKG_ALU_W-1:0] ALU_NOR = 4'hD;
    localparam logic [PKG_ALU_W-1:0] ALU_NOP = 4'h5;

    typedef enum logic [1:0] {
        B_RT    = 2'd0,
        B_IMM   = 2'd1,
        B_SHAMT = 2'd2
    } b_sel_e;

    typedef struct packed {
        logic                  reg_wr;
        logic                  wb_sel;
        logic [PKG_REG_AW-1:0] dst;
    } wb_ctrl_t;

    typedef struct packed {
        logic     mem_rd;
        logic     mem_wr;
        wb_ctrl_t wb;
    } mem_ctrl_t;

    typedef struct packed {
        logic [PKG_ALU_W-1:0] alu_sel;
        b_sel_e               b_sel;
        mem_ctrl_t            mem;
    } ctrl_bundle_t;

    localparam wb_ctrl_t WB_BUBBLE = '{reg_wr: 1'b0, wb_sel: 1'b0, dst: '0};
    localparam mem_ctrl_t MEM_BUBBLE = '{mem_rd: 1'b0, mem_wr: 1'b0, wb: WB_BUBBLE};
    localparam ctrl_bundle_t BUBBLE = '{alu_sel: ALU_NOP, b_sel: B_RT, mem: MEM_BUBBLE};

endpackage

// File: rtl/pipe_control_hazard_unit.sv
// Combinational load-use stall and jump flush logic for the IF/ID boundary.
module hazard_unit #(
    parameter int REG_AW    = 5,
    parameter int HAZARD_EN = 1
) (
    input  logic              id_valid,
    input  logic              id_is_jump,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_dst,
    output logic              stall,
    output logic              pc_en,
    output logic              pc_sel,
    output logic              if_id_en,
    output logic              if_id_flush
);

    logic load_hit;
    logic jump;

    assign load_hit = ex_is_load && (ex_dst != '0) &&
                      ((id_uses_rs && (ex_dst == id_rs)) ||
                       (id_uses_rt && (ex_dst == id_rt)));

    assign stall = (HAZARD_EN != 0) && id_valid && load_hit;
    // A jump reads no registers, so it can never stall; stall still wins defensively.
    assign jump  = id_valid && id_is_jump && !stall;

    assign pc_en       = !stall;
    assign if_id_en    = !stall;
    assign pc_sel      = jump;
    assign if_id_flush = jump;

endmodule

// File: rtl/pipe_control.sv
// Decodes the IF/ID instruction into a control bundle and carries it through
// the ID/EX, EX/MEM and MEM/WB registers; stall/flush come from hazard_unit.
module pipe_control
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int ALU_SEL_W = 4,
    parameter int HAZARD_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic [REG_AW-1:0]    id_rs,
    input  logic [REG_AW-1:0]    id_rt,
    input  logic [REG_AW-1:0]    id_rd,
    output logic                 pc_en,
    output logic                 pc_sel,
    output logic                 if_id_en,
    output logic                 if_id_flush,
    output logic [ALU_SEL_W-1:0] ex_alu_sel,
    output logic [1:0]           ex_b_sel,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 wb_reg_wr,
    output logic                 wb_sel,
    output logic [REG_AW-1:0]    wb_dst,
    output logic                 illegal_op
);

    ctrl_bundle_t ex_d, ex_q, dec;
    mem_ctrl_t    mem_d, mem_q;
    wb_ctrl_t     wb_d, wb_q;
    logic         illegal_d, illegal_q;

    logic                  legal, is_jump, uses_rs, uses_rt, stall;
    logic [PKG_ALU_W-1:0]  d_alu;
    b_sel_e                d_bsel;
    logic                  d_mrd, d_mwr, d_rwr, d_wsel;
    logic [PKG_REG_AW-1:0] d_dst;

    always_comb begin
        d_alu   = ALU_NOP;
        d_bsel  = B_RT;
        d_mrd   = 1'b0;
        d_mwr   = 1'b0;
        d_rwr   = 1'b0;
        d_wsel  = 1'b0;
        d_dst   = '0;
        legal   = 1'b1;
        is_jump = 1'b0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                d_rwr   = 1'b1;
                d_wsel  = 1'b1;
                d_dst   = PKG_REG_AW'(id_rd);
                case (funct)
                    FN_ADD: d_alu = ALU_ADD;
                    FN_SUB: d_alu = ALU_SUB;
                    FN_SLL: begin d_alu = ALU_SLL; d_bsel = B_SHAMT; end
                    FN_SRL: begin d_alu = ALU_SRL; d_bsel = B_SHAMT; end
                    FN_AND: d_alu = ALU_AND;
                    FN_OR:  d_alu = ALU_OR;
                    FN_NOR: d_alu = ALU_NOR;
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                uses_rs = 1'b1;
                d_bsel  = B_IMM;
                d_rwr   = 1'b1;
                d_wsel  = 1'b1;
                d_dst   = PKG_REG_AW'(id_rt);
                d_alu   = (opcode == OP_ADDI) ? ALU_ADD :
                          (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
            end
            OP_LW: begin
                uses_rs = 1'b1;
                d_alu   = ALU_ADD;
                d_bsel  = B_IMM;
                d_mrd   = 1'b1;
                d_rwr   = 1'b1;
                d_dst   = PKG_REG_AW'(id_rt);
            end
            OP_SW: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                d_alu   = ALU_ADD;
                d_bsel  = B_IMM;
                d_mwr   = 1'b1;
            end
            OP_J:    is_jump = 1'b1;
            default: legal = 1'b0;
        endcase
        // $zero is never a real write target.
        if (d_dst == '0) d_rwr = 1'b0;
        dec = '{alu_sel: d_alu, b_sel: d_bsel,
                mem: '{mem_rd: d_mrd, mem_wr: d_mwr,
                       wb: '{reg_wr: d_rwr, wb_sel: d_wsel, dst: d_dst}}};
    end

    hazard_unit #(
        .REG_AW    (REG_AW),
        .HAZARD_EN (HAZARD_EN)
    ) u_hazard (
        .id_valid    (id_valid),
        .id_is_jump  (is_jump && legal),
        .id_uses_rs  (uses_rs && legal),
        .id_uses_rt  (uses_rt && legal),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_is_load  (ex_q.mem.mem_rd),
        .ex_dst      (REG_AW'(ex_q.mem.wb.dst)),
        .stall       (stall),
        .pc_en       (pc_en),
        .pc_sel      (pc_sel),
        .if_id_en    (if_id_en),
        .if_id_flush (if_id_flush)
    );

    always_comb begin
        ex_d      = (id_valid && legal && !is_jump && !stall) ? dec : BUBBLE;
        mem_d     = ex_q.mem;
        wb_d      = mem_q.wb;
        illegal_d = illegal_q || (id_valid && !legal);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= BUBBLE;
            mem_q     <= MEM_BUBBLE;
            wb_q      <= WB_BUBBLE;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_alu_sel = ALU_SEL_W'(ex_q.alu_sel);
    assign ex_b_sel   = ex_q.b_sel;
    assign mem_rd     = mem_q.mem_rd;
    assign mem_wr     = mem_q.mem_wr;
    assign wb_reg_wr  = wb_q.reg_wr;
    assign wb_sel     = wb_q.wb_sel;
    assign wb_dst     = REG_AW'(wb_q.dst);
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: directed scenarios plus a randomized instruction
// stream, checked against a cycle-history reference model of the pipeline.
module tb_pipe_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [5:0] opcode, funct;
    logic [4:0] id_rs, id_rt, id_rd;

    logic       pc_en, pc_sel, if_id_en, if_id_flush;
    logic [3:0] ex_alu_sel;
    logic [1:0] ex_b_sel;
    logic       mem_rd, mem_wr, wb_reg_wr, wb_sel, illegal_op;
    logic [4:0] wb_dst;

    logic       nh_pc_en, nh_pc_sel, nh_if_id_en, nh_if_id_flush;
    logic [3:0] nh_ex_alu_sel;
    logic [1:0] nh_ex_b_sel;
    logic       nh_mem_rd, nh_mem_wr, nh_wb_reg_wr, nh_wb_sel, nh_illegal_op;
    logic [4:0] nh_wb_dst;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_control #(.REG_AW(5), .ALU_SEL_W(4), .HAZARD_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct(funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .pc_en(pc_en), .pc_sel(pc_sel), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .ex_alu_sel(ex_alu_sel), .ex_b_sel(ex_b_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .wb_reg_wr(wb_reg_wr), .wb_sel(wb_sel), .wb_dst(wb_dst), .illegal_op(illegal_op)
    );

    pipe_control #(.REG_AW(5), .ALU_SEL_W(4), .HAZARD_EN(0)) u_dut_nh (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct(funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .pc_en(nh_pc_en), .pc_sel(nh_pc_sel), .if_id_en(nh_if_id_en), .if_id_flush(nh_if_id_flush),
        .ex_alu_sel(nh_ex_alu_sel), .ex_b_sel(nh_ex_b_sel), .mem_rd(nh_mem_rd), .mem_wr(nh_mem_wr),
        .wb_reg_wr(nh_wb_reg_wr), .wb_sel(nh_wb_sel), .wb_dst(nh_wb_dst), .illegal_op(nh_illegal_op)
    );

    // Reference model: what the instruction issued 1, 2 and 3 cycles ago asks for.
    typedef struct packed {
        logic [3:0] alu;
        logic [1:0] bsel;
        logic       mrd, mwr, rwr, wsel;
        logic [4:0] dst;
    } exp_t;

    localparam exp_t BUB = '{alu: 4'h5, bsel: 2'd0, mrd: 1'b0, mwr: 1'b0,
                             rwr: 1'b0, wsel: 1'b0, dst: 5'd0};

    exp_t m_ex, m_mem, m_wb;
    bit   m_ill;

    function automatic void m_reset();
        m_ex  = BUB;
        m_mem = BUB;
        m_wb  = BUB;
        m_ill = 1'b0;
    endfunction

    function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [4:0] rs_f, input logic [4:0] rt_f,
                                       input logic [4:0] rd_f, output exp_t b,
                                       output bit legal, output bit is_j,
                                       output bit rd_rs, output bit rd_rt);
        b = BUB; legal = 1'b1; is_j = 1'b0; rd_rs = 1'b1; rd_rt = 1'b0;
        if (op == 6'h00) begin
            rd_rt = 1'b1; b.rwr = 1'b1; b.wsel = 1'b1; b.dst = rd_f;
            case (fn)
                6'h20: b.alu = 4'h0;
                6'h22: b.alu = 4'h1;
                6'h00: begin b.alu = 4'h2; b.bsel = 2'd2; end
                6'h02: begin b.alu = 4'h3; b.bsel = 2'd2; end
                6'h24: b.alu = 4'h8;
                6'h25: b.alu = 4'h9;
                6'h27: b.alu = 4'hD;
                default: legal = 1'b0;
            endcase
        end else if (op == 6'h08 || op == 6'h0C || op == 6'h0D) begin
            b.alu = (op == 6'h08) ? 4'h0 : (op == 6'h0C) ? 4'h8 : 4'h9;
            b.bsel = 2'd1; b.rwr = 1'b1; b.wsel = 1'b1; b.dst = rt_f;
        end else if (op == 6'h23) begin
            b.alu = 4'h0; b.bsel = 2'd1; b.mrd = 1'b1; b.rwr = 1'b1; b.dst = rt_f;
        end else if (op == 6'h2B) begin
            b.alu = 4'h0; b.bsel = 2'd1; b.mwr = 1'b1; rd_rt = 1'b1;
        end else if (op == 6'h02) begin
            is_j = 1'b1; rd_rs = 1'b0;
        end else begin
            legal = 1'b0;
        end
        if (b.dst == 5'd0) b.rwr = 1'b0;
        if (!legal) begin rd_rs = 1'b0; rd_rt = 1'b0; end
    endfunction

    // Load in EX whose nonzero target is a register the ID instruction reads.
    function automatic bit ref_stall(input bit rd_rs, input bit rd_rt);
        return id_valid && m_ex.mrd && (m_ex.dst != 5'd0) &&
               ((rd_rs && m_ex.dst == id_rs) || (rd_rt && m_ex.dst == id_rt));
    endfunction

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs_f, input logic [4:0] rt_f, input logic [4:0] rd_f);
        id_valid = v; opcode = op; funct = fn; id_rs = rs_f; id_rt = rt_f; id_rd = rd_f;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    endtask

    // Clock one edge and let the model issue what the ID inputs ask for.
    task automatic advance();
        exp_t b;
        bit legal, is_j, rrs, rrt, st;
        ref_decode(opcode, funct, id_rs, id_rt, id_rd, b, legal, is_j, rrs, rrt);
        st = ref_stall(rrs, rrt);
        if (!id_valid || !legal || is_j || st) b = BUB;
        @(posedge clk);
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = b;
        if (id_valid && !legal) m_ill = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        m_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({pc_en, if_id_en, pc_sel, if_id_flush} !== 4'b1100) begin
            n_err++; $display("FAIL reset_comb got %b expected 1100", {pc_en, if_id_en, pc_sel, if_id_flush});
        end
        n_vec++;
        if ({ex_alu_sel, ex_b_sel} !== {4'h5, 2'd0}) begin
            n_err++; $display("FAIL reset_ex got alu=%h b=%0d expected alu=5 b=0", ex_alu_sel, ex_b_sel);
        end
        n_vec++;
        if ({mem_rd, mem_wr, wb_reg_wr, wb_sel, wb_dst, illegal_op} !== 10'd0) begin
            n_err++; $display("FAIL reset_stages got %b expected 0", {mem_rd, mem_wr, wb_reg_wr, wb_sel, wb_dst, illegal_op});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3);
        advance(); idle();
        n_vec++;
        if ({ex_alu_sel, ex_b_sel} !== {4'h0, 2'd0}) begin
            n_err++; $display("FAIL add_ex got alu=%h b=%0d expected alu=0 b=0", ex_alu_sel, ex_b_sel);
        end
        advance(); advance();
        n_vec++;
        if ({wb_reg_wr, wb_sel, wb_dst} !== {1'b1, 1'b1, 5'd3}) begin
            n_err++; $display("FAIL add_wb got wr=%b sel=%b dst=%0d expected 1 1 3", wb_reg_wr, wb_sel, wb_dst);
        end
    endtask

    task automatic test_load_use();
        drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd4, 5'd0);
        advance();
        drive(1'b1, 6'h00, 6'h20, 5'd4, 5'd5, 5'd6);
        n_vec++;
        if ({pc_en, if_id_en, pc_sel} !== 3'b000) begin
            n_err++; $display("FAIL lu_stall got pc_en=%b if_id_en=%b pc_sel=%b expected 000", pc_en, if_id_en, pc_sel);
        end
        advance();
        n_vec++;
        if ({pc_en, if_id_en, ex_alu_sel, mem_rd} !== {2'b11, 4'h5, 1'b1}) begin
            n_err++; $display("FAIL lu_bubble got pc_en=%b if_id_en=%b ex_alu=%h mem_rd=%b expected 1 1 5 1",
                              pc_en, if_id_en, ex_alu_sel, mem_rd);
        end
        advance(); idle();
        n_vec++;
        if ({wb_reg_wr, wb_sel, wb_dst, ex_alu_sel} !== {1'b1, 1'b0, 5'd4, 4'h0}) begin
            n_err++; $display("FAIL lu_lw_wb got wr=%b sel=%b dst=%0d ex_alu=%h expected 1 0 4 0",
                              wb_reg_wr, wb_sel, wb_dst, ex_alu_sel);
        end
        advance();
        n_vec++;
        if (wb_reg_wr !== 1'b0) begin
            n_err++; $display("FAIL lu_wb_bubble got wr=%b expected 0", wb_reg_wr);
        end
        advance();
        n_vec++;
        if ({wb_reg_wr, wb_sel, wb_dst} !== {1'b1, 1'b1, 5'd6}) begin
            n_err++; $display("FAIL lu_add_wb got wr=%b sel=%b dst=%0d expected 1 1 6", wb_reg_wr, wb_sel, wb_dst);
        end
    endtask

    task automatic test_load_r0();
        drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd0, 5'd0);
        advance();
        drive(1'b1, 6'h00, 6'h20, 5'd0, 5'd2, 5'd7);
        n_vec++;
        if ({pc_en, if_id_en} !== 2'b11) begin
            n_err++; $display("FAIL r0_nostall got pc_en=%b if_id_en=%b expected 11", pc_en, if_id_en);
        end
        advance(); idle(); advance();
        n_vec++;
        if (wb_reg_wr !== 1'b0) begin
            n_err++; $display("FAIL r0_lw_wb got wr=%b expected 0", wb_reg_wr);
        end
        advance();
        n_vec++;
        if ({wb_reg_wr, wb_dst} !== {1'b1, 5'd7}) begin
            n_err++; $display("FAIL r0_add_wb got wr=%b dst=%0d expected 1 7", wb_reg_wr, wb_dst);
        end
    endtask

    task automatic test_jump();
        drive(1'b1, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0);
        n_vec++;
        if ({pc_sel, if_id_flush, pc_en, if_id_en} !== 4'b1111) begin
            n_err++; $display("FAIL jump_comb got %b expected 1111", {pc_sel, if_id_flush, pc_en, if_id_en});
        end
        advance(); idle();
        n_vec++;
        if ({ex_alu_sel, pc_sel, if_id_flush} !== {4'h5, 2'b00}) begin
            n_err++; $display("FAIL jump_ex got alu=%h pc_sel=%b flush=%b expected 5 0 0", ex_alu_sel, pc_sel, if_id_flush);
        end
        advance();
        n_vec++;
        if ({mem_rd, mem_wr} !== 2'b00) begin
            n_err++; $display("FAIL jump_mem got rd=%b wr=%b expected 0 0", mem_rd, mem_wr);
        end
        advance();
        n_vec++;
        if (wb_reg_wr !== 1'b0) begin
            n_err++; $display("FAIL jump_wb got wr=%b expected 0", wb_reg_wr);
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3);
        n_vec++;
        if (illegal_op !== 1'b0) begin
            n_err++; $display("FAIL ill_before got %b expected 0", illegal_op);
        end
        advance();
        drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3);
        n_vec++;
        if ({illegal_op, ex_alu_sel} !== {1'b1, 4'h5}) begin
            n_err++; $display("FAIL ill_set got ill=%b ex_alu=%h expected 1 5", illegal_op, ex_alu_sel);
        end
        advance(); idle(); advance(); advance();
        n_vec++;
        if ({illegal_op, wb_reg_wr, wb_dst} !== {1'b1, 1'b1, 5'd3}) begin
            n_err++; $display("FAIL ill_sticky got ill=%b wr=%b dst=%0d expected 1 1 3", illegal_op, wb_reg_wr, wb_dst);
        end
        drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd9, 5'd0);
        advance(); idle();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({illegal_op, ex_alu_sel, ex_b_sel} !== {1'b0, 4'h5, 2'd0}) begin
            n_err++; $display("FAIL ill_async_clr got ill=%b ex_alu=%h b=%0d expected 0 5 0", illegal_op, ex_alu_sel, ex_b_sel);
        end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sw_srl();
        drive(1'b1, 6'h2B, 6'h00, 5'd1, 5'd7, 5'd0);
        advance();
        drive(1'b1, 6'h00, 6'h02, 5'd0, 5'd9, 5'd8);
        advance(); idle();
        n_vec++;
        if ({mem_wr, mem_rd, ex_b_sel, ex_alu_sel} !== {2'b10, 2'd2, 4'h3}) begin
            n_err++; $display("FAIL sw_srl got mem_wr=%b mem_rd=%b b=%0d alu=%h expected 1 0 2 3",
                              mem_wr, mem_rd, ex_b_sel, ex_alu_sel);
        end
        advance();
        n_vec++;
        if (wb_reg_wr !== 1'b0) begin
            n_err++; $display("FAIL sw_wb got wr=%b expected 0", wb_reg_wr);
        end
        advance();
        n_vec++;
        if ({wb_reg_wr, wb_sel, wb_dst} !== {1'b1, 1'b1, 5'd8}) begin
            n_err++; $display("FAIL srl_wb got wr=%b sel=%b dst=%0d expected 1 1 8", wb_reg_wr, wb_sel, wb_dst);
        end
    endtask

    task automatic test_no_hazard();
        drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd4, 5'd0);
        advance();
        drive(1'b1, 6'h00, 6'h20, 5'd4, 5'd5, 5'd6);
        n_vec++;
        if ({nh_pc_en, nh_if_id_en, pc_en} !== 3'b110) begin
            n_err++; $display("FAIL nohaz_stall got nh_pc_en=%b nh_if_id_en=%b pc_en=%b expected 1 1 0",
                              nh_pc_en, nh_if_id_en, pc_en);
        end
        advance(); idle();
        n_vec++;
        if ({nh_ex_alu_sel, nh_ex_b_sel} !== {4'h0, 2'd0}) begin
            n_err++; $display("FAIL nohaz_ex got alu=%h b=%0d expected 0 0", nh_ex_alu_sel, nh_ex_b_sel);
        end
        advance(); advance();
        n_vec++;
        if ({nh_wb_reg_wr, nh_wb_sel, nh_wb_dst} !== {1'b1, 1'b1, 5'd6}) begin
            n_err++; $display("FAIL nohaz_wb got wr=%b sel=%b dst=%0d expected 1 1 6", nh_wb_reg_wr, nh_wb_sel, nh_wb_dst);
        end
    endtask

    task automatic test_random();
        bit hold = 1'b0;
        bit flushed = 1'b0;
        exp_t b;
        bit legal, is_j, rrs, rrt, st, jp;
        logic [19:0] obs, exp_v;
        logic [5:0] op, fn;
        int k;
        for (int i = 0; i < 400; i++) begin
            if (hold) begin
                drive(id_valid, opcode, funct, id_rs, id_rt, id_rd);
            end else if (flushed || $urandom_range(0, 9) == 0) begin
                idle();
            end else begin
                k  = $urandom_range(0, 15);
                fn = 6'($urandom_range(0, 63));
                op = 6'h00;
                case (k)
                    0: fn = 6'h20;  1: fn = 6'h22;  2: fn = 6'h00;  3: fn = 6'h02;
                    4: fn = 6'h24;  5: fn = 6'h25;  6: fn = 6'h27;
                    7: op = 6'h08;  8: op = 6'h0C;  9: op = 6'h0D;
                    11: op = 6'h2B; 12: op = 6'h02;
                    13: op = ($urandom_range(0, 1) == 0) ? 6'h3F : 6'h00;
                    default: op = 6'h23;
                endcase
                if (k == 13 && op == 6'h00) fn = 6'h3F;
                drive(1'b1, op, fn, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                      5'($urandom_range(0, 4)));
            end
            ref_decode(opcode, funct, id_rs, id_rt, id_rd, b, legal, is_j, rrs, rrt);
            st = ref_stall(rrs, rrt);
            jp = id_valid && legal && is_j && !st;
            obs   = {pc_en, pc_sel, if_id_en, if_id_flush, ex_alu_sel, ex_b_sel, mem_rd, mem_wr,
                     wb_reg_wr, wb_sel, wb_dst, illegal_op};
            exp_v = {!st, jp, !st, jp, m_ex.alu, m_ex.bsel, m_mem.mrd, m_mem.mwr,
                     m_wb.rwr, m_wb.wsel, m_wb.dst, m_ill};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++; $display("FAIL random_cycle_%0d got %b expected %b", i, obs, exp_v);
            end
            hold    = st;
            flushed = jp;
            advance();
            if (i % 100 == 99) begin
                rst_n = 1'b0;
                #1;
                n_vec++;
                if ({ex_alu_sel, mem_rd, mem_wr, wb_reg_wr, illegal_op} !== {4'h5, 4'b0000}) begin
                    n_err++; $display("FAIL random_reset_%0d got alu=%h rd=%b wr=%b wb=%b ill=%b expected 5 0 0 0 0",
                                      i, ex_alu_sel, mem_rd, mem_wr, wb_reg_wr, illegal_op);
                end
                m_reset();
                hold = 1'b0;
                flushed = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_load_r0();
        test_jump();
        test_illegal();
        test_sw_srl();
        test_no_hazard();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
